// File: rtl/fifo_arbiter_if.sv
// Requester-to-FIFO handshake bundle. The arbiter sits on the master side;
// requesters and the FIFO enqueue port sit on the slave side.
interface fifo_arbiter_if #(
  parameter int data_size = 8,
  parameter int num_req   = 4,
  parameter int id_w      = (num_req > 2) ? $clog2(num_req) : 1
);
  // valid/ready: a beat moves on a rising clk edge when out_valid and
  // out_ready are both high; req_ready[i] is high only for the granted i.
  logic [num_req-1:0][data_size-1:0] req_data;
  logic [num_req-1:0]                req_valid;
  logic [num_req-1:0]                req_ready;
  logic [data_size-1:0]              out_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [id_w-1:0]                   out_id;

  modport master (
    input  req_data, req_valid, out_ready,
    output req_ready, out_data, out_valid, out_id
  );

  modport slave (
    output req_data, req_valid, out_ready,
    input  req_ready, out_data, out_valid, out_id
  );
endinterface

// File: rtl/fifo_arbiter.sv
// Round-robin burst arbiter feeding a single FIFO enqueue port. A grant lasts
// up to max_burst beats, ends early when the owner drops valid, and flush aborts it.
module fifo_arbiter #(
  parameter int data_size = 8,
  parameter int num_req   = 4,
  parameter int max_burst = 4,
  localparam int id_w     = (num_req > 2) ? $clog2(num_req) : 1,
  localparam int cnt_w    = ($clog2(max_burst + 1) > 1) ? $clog2(max_burst + 1) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  fifo_arbiter_if.master     bus,
  output logic               busy,
  output logic               state_dbg,
  output logic [id_w-1:0]    rr_ptr_dbg,
  output logic [cnt_w-1:0]   burst_cnt_dbg
);

  if (data_size < 1) begin : g_bad_data_size
    $fatal(1, "fifo_arbiter: data_size must be >= 1");
  end
  if (num_req < 2) begin : g_bad_num_req
    $fatal(1, "fifo_arbiter: num_req must be >= 2");
  end
  if (max_burst < 1) begin : g_bad_max_burst
    $fatal(1, "fifo_arbiter: max_burst must be >= 1");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state;
  logic [id_w-1:0]  gnt;
  logic [id_w-1:0]  rr_ptr;
  logic [cnt_w-1:0] burst_cnt;
  logic [id_w-1:0]  pick;
  logic [id_w-1:0]  cand;
  logic             found;
  int               idx;

  function automatic logic [id_w-1:0] wrap_inc(input logic [id_w-1:0] i);
    return (i == id_w'(num_req - 1)) ? '0 : i + 1'b1;
  endfunction

  // First valid requester at or after rr_ptr, wrapping at num_req.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < num_req; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= num_req) idx = idx - num_req;
      cand = id_w'(idx);
      if (!found && bus.req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  wire granted   = (state == GRANT);
  wire gnt_valid = bus.req_valid[gnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (flush) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt       <= pick;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!gnt_valid) begin
            state     <= IDLE;
            rr_ptr    <= wrap_inc(gnt);
            burst_cnt <= '0;
          end else if (bus.out_ready) begin
            if (burst_cnt == cnt_w'(max_burst - 1)) begin
              state     <= IDLE;
              rr_ptr    <= wrap_inc(gnt);
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flush masks the handshake in the same cycle it is asserted.
  always_comb begin
    bus.req_ready = '0;
    bus.out_valid = granted && !flush && gnt_valid;
    bus.out_data  = granted ? bus.req_data[gnt] : '0;
    bus.out_id    = gnt;
    if (granted && !flush) bus.req_ready[gnt] = bus.out_ready;
  end

  assign busy          = granted;
  assign state_dbg     = state;
  assign rr_ptr_dbg    = rr_ptr;
  assign burst_cnt_dbg = burst_cnt;

endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter data_size, default 8: payload width in bits; SHALL be >= 1.
REQ-002 Parameter num_req, default 4: number of requesters; SHALL be >= 2.
REQ-003 Parameter max_burst, default 4: maximum beats per grant; SHALL be >= 1.
REQ-004 Local id_w = max(1, $clog2(num_req)); cnt_w = max(1, $clog2(max_burst+1)).
REQ-005 One clock; reset is asynchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-006 req_data input [num_req][data_size]: per-requester payload.
REQ-007 req_valid input [num_req]: per-requester valid.
REQ-008 req_ready output [num_req]: per-requester ready.
REQ-009 out_data output [data_size]: payload to FIFO enqueue port.
REQ-010 out_valid output 1: drives FIFO enq_valid.
REQ-011 out_ready input 1: from FIFO enq_ready.
REQ-012 out_id output [id_w]: index of the granted requester.
REQ-013 flush input 1: synchronous abort of arbitration, same flush as the FIFO.
REQ-014 busy output 1: high while a grant is held.

Function
REQ-015 FSM states IDLE and GRANT; registers gnt [id_w], rr_ptr [id_w], burst_cnt [cnt_w].
REQ-016 IDLE: out_valid=0, all req_ready=0, busy=0; no transfer in IDLE.
REQ-017 IDLE with any req_valid and no flush: gnt <= first index i = rr_ptr, rr_ptr+1, ... (mod num_req) with req_valid[i]=1; burst_cnt <= 0; next state GRANT (1-cycle arbitration latency).
REQ-018 IDLE with no req_valid: stay IDLE, registers unchanged.
REQ-019 GRANT: out_valid = req_valid[gnt]; out_data = req_data[gnt]; out_id = gnt; req_ready[gnt] = out_ready; req_ready of all other requesters = 0; busy=1.
REQ-020 Outside GRANT, out_data = '0 and out_id = gnt.
REQ-021 Handshake = GRANT and req_valid[gnt] and out_ready; each handshake increments burst_cnt by 1.
REQ-022 Handshake with burst_cnt == max_burst-1: next state IDLE, rr_ptr <= gnt+1 wrapping num_req-1 -> 0, burst_cnt <= 0.
REQ-023 GRANT with req_valid[gnt]=0: next state IDLE, rr_ptr <= gnt+1 (wrapped), burst_cnt <= 0.
REQ-024 GRANT with req_valid[gnt]=1 and out_ready=0: hold state, gnt, burst_cnt; out_data follows req_data[gnt].
REQ-025 Wrap for non-power-of-2 num_req: index num_req-1 increments to 0; indices >= num_req never granted.
REQ-026 flush=1 in any state: out_valid=0 and all req_ready=0 combinationally that cycle (no handshake); next state IDLE, rr_ptr <= 0, burst_cnt <= 0, gnt unchanged.
REQ-027 flush has priority over handshake, burst expiry and new arbitration in the same cycle.
REQ-028 A requester deasserting valid mid-burst forfeits its remaining beats; no beat is lost or duplicated.
REQ-029 Fairness: with all requesters continuously valid and out_ready=1, each receives exactly max_burst beats per rotation, in ascending index order.
REQ-030 Invalid parameters (REQ-001..003) SHALL raise $fatal at elaboration.

Reset
REQ-031 rst_n low asynchronously forces state IDLE, gnt=0, rr_ptr=0, burst_cnt=0; outputs out_valid=0, req_ready=0, busy=0, out_id=0, out_data='0.
REQ-032 Reset mid-burst discards the grant; the first arbitration after release starts from index 0.

Verification (data_size=8, num_req=4, max_burst=2)
REQ-033 Reset: drive req_valid=4'b1111 during rst_n=0 -> out_valid=0, req_ready=0, busy=0; first cycle after release IDLE, next cycle GRANT gnt=0.
REQ-034 Single requester: req_valid[2]=1 steady, data 0xA0,0xA1,..., out_ready=1 -> beats 0xA0,0xA1 with out_id=2, one IDLE cycle, then 0xA2,0xA3; 2 beats per 3 cycles.
REQ-035 Round robin: all valid, out_ready=1 -> out_id sequence 0,0,1,1,2,2,3,3,0,0 with one IDLE cycle between grants.
REQ-036 Backpressure: gnt=1, out_ready=0 for 3 cycles -> out_valid=1, out_data stable, req_ready[1]=0, burst_cnt unchanged; release -> 2 beats then IDLE.
REQ-037 Flush mid-burst: gnt=3 after 1 beat, flush=1 with out_ready=1 -> out_valid=0, no beat consumed; next grant with all valid is gnt=0.
REQ-038 Drop: gnt=1, req_valid[1]=0 after 1 beat -> IDLE next cycle, rr_ptr=2; with req_valid[0],[2] high, next gnt=2.
